// File: rtl/rf_wport_arbiter_if.sv
// Register-file write-port arbitration bundle: WB request, AU result return, RF write.
// Latency: none, plain signal container.
// Backpressure: wb_hold stalls WB, au_ready throttles AU; no flow control on the RF side.
// Optional RF_ARB_STAT_EN adds the stat_conflict / stat_hold counters to the bundle.
interface rf_wport_arbiter_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          wb_valid;
   logic          wb_we;
   logic [4:0]    wb_waddr;
   logic [31:0]   wb_wdata;
   logic          wb_hold;

   logic          au_valid;
   logic [4:0]    au_waddr;
   logic [31:0]   au_wdata;
   logic          au_ready;

   logic          rf_we;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;
   logic          grant_src;
   logic [31:0]   busy_mask;
   logic [CW-1:0] fifo_count;
`ifdef RF_ARB_STAT_EN
   logic [31:0]   stat_conflict;
   logic [31:0]   stat_hold;
`endif

   // Arbiter side
   modport slave (
      input  wb_valid, wb_we, wb_waddr, wb_wdata,
      input  au_valid, au_waddr, au_wdata,
      output wb_hold, au_ready,
      output rf_we, rf_waddr, rf_wdata, grant_src, busy_mask, fifo_count
`ifdef RF_ARB_STAT_EN
      , output stat_conflict, stat_hold
`endif
   );

   // Pipeline / AU side
   modport master (
      output wb_valid, wb_we, wb_waddr, wb_wdata,
      output au_valid, au_waddr, au_wdata,
      input  wb_hold, au_ready,
      input  rf_we, rf_waddr, rf_wdata, grant_src, busy_mask, fifo_count
`ifdef RF_ARB_STAT_EN
      , input stat_conflict, stat_hold
`endif
   );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between WB (priority) and a buffered AU result FIFO with starvation guard.
// Latency: grant and write are same-cycle combinational; AU entries wait in the FIFO until a free slot.
// Backpressure: au_ready drops when the FIFO is full and not draining; wb_hold stalls WB for one cycle.
// Optional RF_ARB_STAT_EN adds conflict/hold statistics counters.
module rf_wport_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic clk,
   input  logic reset,
   rf_wport_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [4:0]    q_waddr [DEPTH];
   logic [31:0]   q_wdata [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [SW-1:0] starve_q;
   logic [SW-1:0] starve_d;
   logic          hold_q;
   logic [4:0]    last_waddr;
   logic [31:0]   last_wdata;

   logic          fifo_empty;
   logic          fifo_full;
   logic          wb_req;
   logic          head_gnt;
   logic          wb_gnt;
   logic          byp_gnt;
   logic          any_gnt;
   logic          deq;
   logic          push;
   logic          au_rdy;
   logic          sel_we;
   logic [4:0]    sel_waddr;
   logic [31:0]   sel_wdata;
   logic [31:0]   mask;
   logic [AW-1:0] off;

   // Port grant: held WB yields to the head, else WB, else head, else AU bypass
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == FULL_CNT);
      wb_req     = bus.wb_valid & bus.wb_we & ~hold_q;
      head_gnt   = ~reset & ~fifo_empty & (hold_q | ~wb_req);
      wb_gnt     = ~reset & ~head_gnt & wb_req;
      byp_gnt    = ~reset & fifo_empty & ~wb_req & bus.au_valid;
      any_gnt    = head_gnt | wb_gnt | byp_gnt;
      deq        = head_gnt;
      au_rdy     = ~reset & (~fifo_full | deq);
      push       = bus.au_valid & au_rdy & ~byp_gnt;

      sel_we    = 1'b0;
      sel_waddr = last_waddr;
      sel_wdata = last_wdata;
      if (head_gnt) begin
         // r0 entries still burn their slot but never write
         sel_we    = (q_waddr[rd_ptr] != 5'd0);
         sel_waddr = q_waddr[rd_ptr];
         sel_wdata = q_wdata[rd_ptr];
      end else if (wb_gnt) begin
         sel_we    = 1'b1;
         sel_waddr = bus.wb_waddr;
         sel_wdata = bus.wb_wdata;
      end else if (byp_gnt) begin
         sel_we    = (bus.au_waddr != 5'd0);
         sel_waddr = bus.au_waddr;
         sel_wdata = bus.au_wdata;
      end

      count_d = count_q + CW'(push) - CW'(deq);

      if (fifo_empty || deq)
         starve_d = '0;
      else if (starve_q < STARVE_MAX)
         starve_d = starve_q + SW'(1);
      else
         starve_d = starve_q;
   end

   // Pending-write mask over occupied entries; a head being dequeued stays visible until the edge
   always_comb begin
      mask = '0;
      off  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = AW'(i) - rd_ptr;
         if (CW'(off) < count_q)
            mask[q_waddr[i]] = 1'b1;
      end
      mask[0] = 1'b0;
   end

   // FIFO storage; contents need no reset since occupancy gates every use
   always_ff @(posedge clk) begin
      if (push) begin
         q_waddr[wr_ptr] <= bus.au_waddr;
         q_wdata[wr_ptr] <= bus.au_wdata;
      end
   end

   // Pointers, occupancy, starvation counter, registered hold and last driven RF address/data
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         hold_q     <= 1'b0;
         last_waddr <= '0;
         last_wdata <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (deq)
            rd_ptr <= rd_ptr + AW'(1);
         count_q  <= count_d;
         starve_q <= starve_d;
         // Counter at the limit implies a non-empty FIFO next cycle, so hold never hits an empty FIFO
         hold_q   <= (starve_d == STARVE_MAX);
         if (any_gnt) begin
            last_waddr <= sel_waddr;
            last_wdata <= sel_wdata;
         end
      end
   end

`ifdef RF_ARB_STAT_EN
   logic [31:0] stat_conflict_q;
   logic [31:0] stat_hold_q;
   logic        conflict;

   // AU is waiting whenever WB owns the port while the FIFO holds data or a bypass is being refused
   always_comb begin
      conflict = wb_gnt & (~fifo_empty | bus.au_valid);
   end

   // Free-running statistics, wrap at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_conflict_q <= '0;
         stat_hold_q     <= '0;
      end else begin
         if (conflict)
            stat_conflict_q <= stat_conflict_q + 32'd1;
         if (hold_q)
            stat_hold_q <= stat_hold_q + 32'd1;
      end
   end

   assign bus.stat_conflict = stat_conflict_q;
   assign bus.stat_hold     = stat_hold_q;
`endif

   assign bus.wb_hold    = hold_q;
   assign bus.au_ready   = au_rdy;
   assign bus.rf_we      = sel_we;
   assign bus.rf_waddr   = sel_waddr;
   assign bus.rf_wdata   = sel_wdata;
   assign bus.grant_src  = head_gnt | byp_gnt;
   assign bus.busy_mask  = mask;
   assign bus.fifo_count = count_q;

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between two requesters: the in-order WB stage and an out-of-pipeline long-latency unit (AU: divider/multiplier result return).
- WB has priority. AU results are buffered in a small FIFO and drained on idle WB cycles.
- A starvation guard stalls WB for one cycle so the AU head can write.
- Exports a pending-write mask that the ID hazard logic uses for interlock.

Parameters:
- DEPTH, 4, AU result FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may wait ungranted before WB is held.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wb_valid  in  1  WB stage holds a valid instruction
- wb_we  in  1  WB instruction writes the register file (gr_we)
- wb_waddr  in  5  WB destination register
- wb_wdata  in  32  WB final result
- wb_hold  out  1  forces WB_ready_go low this cycle; WB keeps its instruction
- au_valid  in  1  AU result available
- au_waddr  in  5  AU destination register
- au_wdata  in  32  AU result
- au_ready  out  1  arbiter accepts the AU result this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- grant_src  out  1  0 = WB owns the port, 1 = AU (FIFO head or bypass)
- busy_mask  out  32  bit r set when the FIFO holds a pending write to register r
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset: FIFO empty, pointers 0, fifo_count=0, starve counter 0, wb_hold=0, busy_mask=0.
- Reset: rf_we=0 and au_ready=0 while reset is high.
- Reset mid-operation discards all buffered AU entries.
- wb_req = wb_valid & wb_we & ~wb_hold.
- Port grant is combinational, with same-cycle write and zero latency, in this priority order:
  1. wb_hold=1 and FIFO non-empty: grant the FIFO head; WB inputs are ignored.
  2. wb_req=1: grant WB; rf_* = wb_*; grant_src=0.
  3. FIFO non-empty: grant the FIFO head; dequeue at the clock edge; grant_src=1.
  4. FIFO empty and au_valid=1: bypass, rf_* = au_*; no enqueue; grant_src=1.
  5. Otherwise rf_we=0; rf_waddr and rf_wdata hold their last values (don't-care).
- Enqueue:
  - au_ready = ~reset & (FIFO not full | dequeue this cycle).
  - au_valid & au_ready & not bypassed pushes {au_waddr, au_wdata}.
  - Enqueue and dequeue in the same cycle are allowed at any occupancy, including full.
  - AU results are never dropped. When au_ready=0, the AU holds its result.
- Register r0:
  - An AU entry with waddr=0 is accepted and consumes a grant slot, but rf_we=0 for that slot.
  - busy_mask[0] is always 0. WB writes to r0 pass through unchanged.
- Ordering: FIFO drains strictly in order. The arbiter never reorders WB against AU. WAW and RAW protection are the hazard logic's job, via busy_mask.
- busy_mask is combinational: the OR of one-hot(waddr) over valid entries. A head being dequeued stays visible until the edge.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not granted; saturates at STARVE_LIMIT.
  - Clears on every dequeue and whenever the FIFO is empty.
- wb_hold:
  - Registered; set the cycle after the counter reaches STARVE_LIMIT.
  - Lasts exactly one cycle, because the head is dequeued in that cycle and the counter clears.
  - Not asserted while the FIFO is empty.
- Pointers wrap modulo DEPTH. Full/empty are resolved via fifo_count; no pointer-MSB trick is required.

Optional Feature:
- Macro: RF_ARB_STAT_EN.
- Defined:
  - Adds outputs stat_conflict[31:0] and stat_hold[31:0].
  - stat_conflict counts cycles where the AU is waiting (FIFO non-empty, or au_valid with bypass blocked) while WB owns the port.
  - stat_hold counts wb_hold cycles.
  - Both are cleared on reset and wrap at 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Idle WB (wb_valid=0), au_valid=1, au_waddr=5, au_wdata=0x1234 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, grant_src=1, fifo_count stays 0.
2. WB busy: wb_req=1 every cycle and AU pushes regs 1,2,3,4 -> fifo_count reaches 4 and au_ready=0 on a fifth attempt; busy_mask=0x1E.
3. Continuation of scenario 2: wb_valid=0 -> regs 1,2,3,4 written in order on 4 consecutive cycles; busy_mask clears bit by bit.
4. Starvation: wb_req=1 continuously, one entry (reg 7) queued -> wb_hold=1 on exactly one cycle, 9 cycles after the enqueue (the counter hits 8, then the registered hold). In that cycle rf_waddr=7 and grant_src=1. wb_hold=0 the next cycle and WB's pending write then completes.
5. Full FIFO with a simultaneous dequeue and enqueue (reg 9) -> au_ready=1, fifo_count stays 4, reg 9 is drained last. Separately, an AU entry with waddr=0 -> accepted, rf_we=0 in its slot.
6. Reset asserted with 3 entries queued -> next cycle fifo_count=0, busy_mask=0, wb_hold=0, rf_we=0 while reset is high. With RF_ARB_STAT_EN defined, stat counters read 0.
